// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout FSM with per-denomination inventory and a hopper handshake.
// Optional feature macro CHANGE_AUDIT_EN adds a saturating paid_total output.
module change_dispenser #(
    parameter int AMT_W       = 4,
    parameter int DENOM_HI    = 5,
    parameter int DENOM_MID   = 2,
    parameter int DENOM_LO    = 1,
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 20,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    output logic             change_ready,
    output logic [1:0]       coin_sel,
    output logic             coin_eject,
    input  logic             hopper_done,
    input  logic             refill,
    output logic             busy,
    output logic             done,
    output logic             shortfall,
`ifdef CHANGE_AUDIT_EN
    output logic [AMT_W-1:0] remaining,
    output logic [15:0]      paid_total
`else
    output logic [AMT_W-1:0] remaining
`endif
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [AMT_W-1:0]   D_HI       = AMT_W'(DENOM_HI);
    localparam logic [AMT_W-1:0]   D_MID      = AMT_W'(DENOM_MID);
    localparam logic [AMT_W-1:0]   D_LO       = AMT_W'(DENOM_LO);
    localparam logic [INV_W-1:0]   INV_RST    = INV_W'(INV_INIT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_LO   = 2'b01,
        SEL_MID  = 2'b10,
        SEL_HI   = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT,
        S_FINISH,
        S_FAULT
    } state_e;

    function automatic logic [AMT_W-1:0] denom_of(input coin_e sel);
        logic [AMT_W-1:0] value;
        unique case (sel)
            SEL_HI:  value = D_HI;
            SEL_MID: value = D_MID;
            SEL_LO:  value = D_LO;
            default: value = '0;
        endcase
        return value;
    endfunction

    state_e             state_q, state_d;
    coin_e              coin_sel_q, coin_sel_d;
    logic [AMT_W-1:0]   remaining_q, remaining_d;
    logic               shortfall_q, shortfall_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [INV_W-1:0]   inv_hi_q, inv_hi_d;
    logic [INV_W-1:0]   inv_mid_q, inv_mid_d;
    logic [INV_W-1:0]   inv_lo_q, inv_lo_d;
    logic               change_ready_q;
    logic               coin_eject_q;
    logic               busy_q;
    logic               done_q;
    logic [AMT_W-1:0]   coin_value;

    assign coin_value = denom_of(coin_sel_q);

    // NOTE: every variable gets a default at the top of an always_comb so no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d     = state_q;
        coin_sel_d  = coin_sel_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        timer_d     = timer_q;

        unique case (state_q)
            S_IDLE: begin
                if (change_valid && change_ready_q) begin
                    remaining_d = change_amount;
                    shortfall_d = 1'b0;
                    coin_sel_d  = SEL_NONE;
                    state_d     = (change_amount == '0) ? S_FINISH : S_SELECT;
                end
            end

            S_SELECT: begin
                // Greedy and final: the largest coin that fits and is in stock.
                if (remaining_q >= D_HI && inv_hi_q != '0) begin
                    coin_sel_d = SEL_HI;
                    state_d    = S_EJECT;
                end else if (remaining_q >= D_MID && inv_mid_q != '0) begin
                    coin_sel_d = SEL_MID;
                    state_d    = S_EJECT;
                end else if (remaining_q >= D_LO && inv_lo_q != '0) begin
                    coin_sel_d = SEL_LO;
                    state_d    = S_EJECT;
                end else begin
                    coin_sel_d = SEL_NONE;
                    state_d    = S_FAULT;
                end
            end

            S_EJECT: begin
                timer_d = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // timer_q counts WAIT cycles already spent, so WAIT lasts at most TIMEOUT_CYC cycles.
                if (hopper_done) begin
                    remaining_d = remaining_q - coin_value;
                    coin_sel_d  = SEL_NONE;
                    state_d     = (remaining_d == '0) ? S_FINISH : S_SELECT;
                end else if (timer_q == TIMER_LAST) begin
                    coin_sel_d = SEL_NONE;
                    state_d    = S_FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_FINISH, S_FAULT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_FAULT) begin
            shortfall_d = 1'b1;
        end
    end

    always_comb begin
        inv_hi_d  = inv_hi_q;
        inv_mid_d = inv_mid_q;
        inv_lo_d  = inv_lo_q;

        if (state_q == S_EJECT) begin
            unique case (coin_sel_q)
                SEL_HI:  inv_hi_d  = inv_hi_q - 1'b1;
                SEL_MID: inv_mid_d = inv_mid_q - 1'b1;
                SEL_LO:  inv_lo_d  = inv_lo_q - 1'b1;
                default: ;
            endcase
        end

        // Refill overrides a decrement landing in the same cycle.
        if (refill) begin
            inv_hi_d  = INV_RST;
            inv_mid_d = INV_RST;
            inv_lo_d  = INV_RST;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            coin_sel_q     <= SEL_NONE;
            remaining_q    <= '0;
            shortfall_q    <= 1'b0;
            timer_q        <= '0;
            change_ready_q <= 1'b0;
            coin_eject_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            coin_sel_q     <= coin_sel_d;
            remaining_q    <= remaining_d;
            shortfall_q    <= shortfall_d;
            timer_q        <= timer_d;
            change_ready_q <= (state_d == S_IDLE);
            coin_eject_q   <= (state_d == S_EJECT);
            busy_q         <= (state_d != S_IDLE);
            done_q         <= (state_d == S_FINISH) || (state_d == S_FAULT);
        end
    end

    // NOTE: the inventory is three small counters, not a RAM, so it is reset
    // directly to its full-stock value rather than left uninitialised.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_hi_q  <= INV_RST;
            inv_mid_q <= INV_RST;
            inv_lo_q  <= INV_RST;
        end else begin
            inv_hi_q  <= inv_hi_d;
            inv_mid_q <= inv_mid_d;
            inv_lo_q  <= inv_lo_d;
        end
    end

`ifdef CHANGE_AUDIT_EN
    logic [15:0] paid_total_q, paid_total_d;
    logic [16:0] paid_sum;

    always_comb begin
        paid_sum     = {1'b0, paid_total_q} + 17'(coin_value);
        paid_total_d = paid_total_q;
        if (state_q == S_WAIT && hopper_done) begin
            paid_total_d = paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            paid_total_q <= '0;
        end else begin
            paid_total_q <= paid_total_d;
        end
    end

    assign paid_total = paid_total_q;
`endif

    assign change_ready = change_ready_q;
    assign coin_sel     = coin_sel_q;
    assign coin_eject   = coin_eject_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign shortfall    = shortfall_q;
    assign remaining    = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed scenarios plus randomized requests against
// a greedy-payout reference model (inventory per denomination, sticky shortfall).
module tb_change_dispenser;

    localparam int AMT_W       = 4;
    localparam int INV_INIT    = 1;
    localparam int TIMEOUT_CYC = 255;
    localparam int DEN [3]     = '{5, 2, 1};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             change_valid = 1'b0;
    logic [AMT_W-1:0] change_amount = '0;
    logic             hopper_done = 1'b0;
    logic             refill = 1'b0;
    logic             change_ready;
    logic [1:0]       coin_sel;
    logic             coin_eject;
    logic             busy;
    logic             done;
    logic             shortfall;
    logic [AMT_W-1:0] remaining;
`ifdef CHANGE_AUDIT_EN
    logic [15:0]      paid_total;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int inv [3];
    int model_paid = 0;
    bit exp_short  = 1'b0;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W      (AMT_W),
        .DENOM_HI   (5),
        .DENOM_MID  (2),
        .DENOM_LO   (1),
        .INV_W      (6),
        .INV_INIT   (INV_INIT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .change_ready (change_ready),
        .coin_sel     (coin_sel),
        .coin_eject   (coin_eject),
        .hopper_done  (hopper_done),
        .refill       (refill),
        .busy         (busy),
        .done         (done),
        .shortfall    (shortfall),
`ifdef CHANGE_AUDIT_EN
        .remaining    (remaining),
        .paid_total   (paid_total)
`else
        .remaining    (remaining)
`endif
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) inv[i] = INV_INIT;
        model_paid = 0;
        exp_short  = 1'b0;
    endtask

    // Largest denomination that fits and is in stock, or -1.
    function automatic int pick(input int rem);
        for (int i = 0; i < 3; i++) begin
            if (DEN[i] <= rem && inv[i] > 0) return i;
        end
        return -1;
    endfunction

    task automatic refill_pulse();
        refill = 1'b1;
        step();
        refill = 1'b0;
        for (int i = 0; i < 3; i++) inv[i] = INV_INIT;
    endtask

    task automatic wait_event(input int budget, output int at, output bit seen);
        seen = 1'b0;
        at   = cyc;
        for (int i = 0; i < budget && !seen; i++) begin
            if (coin_eject === 1'b1 || done === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end else begin
                step();
            end
        end
    endtask

    // One complete request: accept, follow every coin, answer the hopper, check the end.
    task automatic do_request(input int amt, input int dmin, input int dmax, input bit withhold,
                              input bit refill_first, input bit poke, input string tag);
        int rem;
        int k;
        int at;
        int exp_at;
        bit seen;
        bit first;
        bit fin;
        for (int i = 0; i < 20 && change_ready !== 1'b1; i++) step();
        total++;
        if (change_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_wait: change_ready=%b want 1", tag, change_ready);
        end
        change_valid  = 1'b1;
        change_amount = AMT_W'(amt);
        step();
        change_valid  = 1'b0;
        change_amount = AMT_W'($urandom);
        exp_short = 1'b0;
        rem   = amt;
        first = 1'b1;
        fin   = 1'b0;
        total++;
        if (remaining !== AMT_W'(amt) || shortfall !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: remaining=%0d shortfall=%b busy=%b want %0d 0 1",
                     tag, remaining, shortfall, busy, amt);
        end
        if (amt == 0) begin
            total++;
            if (done !== 1'b1 || coin_eject !== 1'b0) begin
                bad++;
                $display("FAIL %s zero_done: done=%b eject=%b want 1 0", tag, done, coin_eject);
            end
            fin = 1'b1;
        end
        while (!fin) begin
            k      = pick(rem);
            exp_at = cyc + 1;
            wait_event(8, at, seen);
            total++;
            if (!seen || at != exp_at) begin
                bad++;
                $display("FAIL %s event_time: seen=%b cycle=%0d want %0d", tag, seen, at, exp_at);
                if (!seen) return;
            end
            if (k < 0) begin
                total++;
                if (done !== 1'b1 || coin_eject !== 1'b0 || shortfall !== 1'b1 ||
                    remaining !== AMT_W'(rem)) begin
                    bad++;
                    $display("FAIL %s no_coin: done=%b eject=%b shortfall=%b remaining=%0d want 1 0 1 %0d",
                             tag, done, coin_eject, shortfall, remaining, rem);
                end
                exp_short = 1'b1;
                fin = 1'b1;
            end else begin
                total++;
                if (coin_eject !== 1'b1 || done !== 1'b0 || coin_sel !== 2'(3 - k)) begin
                    bad++;
                    $display("FAIL %s coin: eject=%b done=%b coin_sel=%0d want 1 0 %0d",
                             tag, coin_eject, done, coin_sel, 3 - k);
                end
                inv[k]--;
                if (refill_first && first) begin
                    refill = 1'b1;
                    for (int i = 0; i < 3; i++) inv[i] = INV_INIT;
                end
                first = 1'b0;
                step();
                refill = 1'b0;
                if (withhold) begin
                    exp_at = at + TIMEOUT_CYC + 1;
                    wait_event(TIMEOUT_CYC + 20, at, seen);
                    total++;
                    if (!seen || at != exp_at || done !== 1'b1 || coin_eject !== 1'b0 ||
                        shortfall !== 1'b1 || remaining !== AMT_W'(rem)) begin
                        bad++;
                        $display("FAIL %s timeout: cycle=%0d done=%b eject=%b shortfall=%b remaining=%0d want %0d 1 0 1 %0d",
                                 tag, at, done, coin_eject, shortfall, remaining, exp_at, rem);
                    end
                    exp_short = 1'b1;
                    fin = 1'b1;
                end else begin
                    if (poke) begin
                        change_valid  = 1'b1;
                        change_amount = 4'd3;
                    end
                    repeat ($urandom_range(dmax, dmin)) step();
                    hopper_done  = 1'b1;
                    change_valid = 1'b0;
                    step();
                    hopper_done = 1'b0;
                    rem -= DEN[k];
                    model_paid = (model_paid + DEN[k] > 65535) ? 65535 : model_paid + DEN[k];
                    if (rem == 0) begin
                        total++;
                        if (done !== 1'b1 || coin_eject !== 1'b0 || shortfall !== 1'b0 ||
                            remaining !== '0 || coin_sel !== 2'b00) begin
                            bad++;
                            $display("FAIL %s finish: done=%b eject=%b shortfall=%b remaining=%0d coin_sel=%0d want 1 0 0 0 0",
                                     tag, done, coin_eject, shortfall, remaining, coin_sel);
                        end
                        fin = 1'b1;
                    end
                end
            end
        end
`ifdef CHANGE_AUDIT_EN
        total++;
        if (paid_total !== 16'(model_paid)) begin
            bad++;
            $display("FAIL %s paid_total: got %0d want %0d", tag, paid_total, model_paid);
        end
`endif
        step();
        total++;
        if (change_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || shortfall !== exp_short) begin
            bad++;
            $display("FAIL %s tail: ready=%b busy=%b done=%b shortfall=%b want 1 0 0 %b",
                     tag, change_ready, busy, done, shortfall, exp_short);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if (change_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || coin_eject !== 1'b0 ||
            coin_sel !== 2'b00 || shortfall !== 1'b0 || remaining !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b eject=%b sel=%0d short=%b rem=%0d want all 0",
                     change_ready, busy, done, coin_eject, coin_sel, shortfall, remaining);
        end
`ifdef CHANGE_AUDIT_EN
        total++;
        if (paid_total !== 16'd0) begin
            bad++;
            $display("FAIL reset_paid_total: got %0d want 0", paid_total);
        end
`endif
        rst = 1'b0;
        step();
        model_reset();
        total++;
        if (change_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b want 1 0", change_ready, busy);
        end
    endtask

    task automatic test_greedy();
        refill_pulse();
        do_request(8, 1, 1, 1'b0, 1'b0, 1'b0, "greedy8");
    endtask

    task automatic test_zero();
        do_request(0, 0, 0, 1'b0, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_shortfall();
        refill_pulse();
        do_request(1, 0, 2, 1'b0, 1'b0, 1'b0, "short_first");
        do_request(1, 0, 2, 1'b0, 1'b0, 1'b0, "short_second");
    endtask

    task automatic test_timeout();
        refill_pulse();
        do_request(5, 0, 0, 1'b1, 1'b0, 1'b0, "timeout");
    endtask

    task automatic test_refill_eject();
        refill_pulse();
        do_request(5, 2, 3, 1'b0, 1'b1, 1'b1, "refill_eject");
        do_request(5, 0, 1, 1'b0, 1'b0, 1'b0, "after_refill");
    endtask

    task automatic test_reset_midpayout();
        refill_pulse();
        change_valid  = 1'b1;
        change_amount = 4'd8;
        step();
        change_valid = 1'b0;
        step();
        total++;
        if (coin_eject !== 1'b1 || coin_sel !== 2'b11) begin
            bad++;
            $display("FAIL abort_eject: eject=%b coin_sel=%0d want 1 3", coin_eject, coin_sel);
        end
        step();
        rst         = 1'b1;
        hopper_done = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || coin_eject !== 1'b0 || done !== 1'b0 || remaining !== '0 ||
            coin_sel !== 2'b00 || change_ready !== 1'b0 || shortfall !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset: busy=%b eject=%b done=%b rem=%0d sel=%0d ready=%b short=%b want all 0",
                     busy, coin_eject, done, remaining, coin_sel, change_ready, shortfall);
        end
        rst = 1'b0;
        step();
        hopper_done = 1'b0;
        model_reset();
        total++;
        if (change_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_ready: ready=%b busy=%b want 1 0", change_ready, busy);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || change_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_ignore: busy=%b done=%b ready=%b want 0 0 1", busy, done, change_ready);
        end
        do_request(5, 0, 1, 1'b0, 1'b0, 1'b0, "abort_after");
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1, 0) == 1) refill_pulse();
            if ($urandom_range(3, 0) == 0) begin
                hopper_done = 1'b1;
                step();
                hopper_done = 1'b0;
            end
            do_request(int'($urandom_range(15, 0)), 0, 3, ($urandom_range(9, 0) == 0),
                       1'b0, 1'b0, "random");
        end
    endtask

`ifdef CHANGE_AUDIT_EN
    task automatic test_audit();
        test_reset();
        do_request(8, 0, 2, 1'b0, 1'b0, 1'b0, "audit_8");
        refill_pulse();
        do_request(7, 0, 2, 1'b0, 1'b0, 1'b0, "audit_7");
        total++;
        if (paid_total !== 16'd15) begin
            bad++;
            $display("FAIL audit_sum: paid_total=%0d want 15", paid_total);
        end
        test_reset();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_greedy();
        test_zero();
        test_shortfall();
        test_timeout();
        test_refill_eject();
        test_reset_midpayout();
        test_random();
`ifdef CHANGE_AUDIT_EN
        test_audit();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
